// File: rtl/edge_mask_tx_pkg.sv
// edge_mask_tx_pkg: shared constants, FSM encoding and beat-slice helper for the edge-mask stream.
package edge_stream_pkg;
  localparam int WORD_W    = 32;
  localparam int BEAT_W    = 128;
  localparam int BEATS     = 32;
  localparam int MAP_WORDS = 128;
  localparam int SEL_W     = 5;
  localparam int ADDR_W    = 7;
  localparam int MAP_W     = WORD_W * MAP_WORDS;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] SEND  = 2'd2;
  typedef logic [MAP_W-1:0] map_t;
  // Beat k is the k-th 128-bit slice counted from the top; ~k gives BEATS-1-k.
  function automatic logic [BEAT_W-1:0] beat_slice(input map_t map, input logic [SEL_W-1:0] k);
    return map[{~k, 7'd0} +: BEAT_W];
  endfunction
endpackage

// File: rtl/edge_mask_tx_if.sv
// edge_mask_tx_if: host write port, frame request and stream outputs of edge_mask_tx.
interface edge_mask_tx_if;
  import edge_stream_pkg::*;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              wr_drop;
  logic              start;
  logic [SEL_W-1:0]  rx_sel;
  logic [BEAT_W-1:0] edge_mask;
  logic              mask_valid;
  logic [SEL_W-1:0]  beat_idx;
  logic              busy;
  logic              done;
  modport slave (input wr_en, wr_addr, wr_data, start, rx_sel,
                 output wr_drop, edge_mask, mask_valid, beat_idx, busy, done);
  modport master (output wr_en, wr_addr, wr_data, start, rx_sel,
                  input wr_drop, edge_mask, mask_valid, beat_idx, busy, done);
endinterface

// File: rtl/edge_mask_tx_store.sv
// edge_map_store: 128x32 word-write edge map with a 128-bit beat read port.
module edge_map_store
  import edge_stream_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [SEL_W-1:0]  ridx_i,
  output logic [BEAT_W-1:0] rdata_o
);
  map_t map_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) map_q <= '0;
    else if (we_i) map_q[{waddr_i, 5'd0} +: WORD_W] <= wdata_i;
  assign rdata_o = beat_slice(map_q, ridx_i);
endmodule

// File: rtl/edge_mask_tx.sv
// edge_mask_tx: streams a 4096-bit edge map as 32 beats phase-locked to rx_sel.
// Build option EDGE_TX_REPEAT_EN: start held at frame end chains the next frame gap-free.
module edge_mask_tx
  import edge_stream_pkg::*;
(
  input logic           CLK,
  input logic           RST,
  edge_mask_tx_if.slave bus
);
  logic [1:0]        state_q, state_d;
  logic [BEAT_W-1:0] mask_q, mask_d, beat;
  logic [SEL_W-1:0]  idx_q, idx_d, rd_idx;
  logic              valid_q, done_q, drop_q;
  logic              busy, last, arm_go, send_more, rep, load;
  assign busy      = state_q != IDLE;
  assign last      = idx_q == SEL_W'(BEATS - 1);
  assign arm_go    = state_q == ARMED && bus.rx_sel == SEL_W'(BEATS - 1);
  assign send_more = state_q == SEND && !last;
`ifdef EDGE_TX_REPEAT_EN
  assign rep = state_q == SEND && last && bus.start;
`else
  assign rep = 1'b0;
`endif
  assign load   = arm_go || send_more || rep;
  assign rd_idx = send_more ? idx_q + 1'b1 : '0;
  edge_map_store u_store (
    .clk    (CLK),
    .rst    (RST),
    .we_i   (bus.wr_en && !busy),
    .waddr_i(bus.wr_addr),
    .wdata_i(bus.wr_data),
    .ridx_i (rd_idx),
    .rdata_o(beat)
  );
  always_comb begin
    state_d = state_q == IDLE  ? (bus.start ? ARMED : IDLE) :
              state_q == ARMED ? (arm_go ? SEND : ARMED) :
              (last && !rep)   ? IDLE : SEND;
    mask_d  = load ? beat : '0;
    idx_d   = load ? rd_idx : '0;
  end
  // Idle beats are forced to zero: the receiver ORs every frame unconditionally.
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= IDLE;
      mask_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      valid_q <= load;
      done_q  <= state_q == SEND && last;
      drop_q  <= bus.wr_en && busy;
    end
  assign bus.edge_mask  = mask_q;
  assign bus.mask_valid = valid_q;
  assign bus.beat_idx   = idx_q;
  assign bus.busy       = busy;
  assign bus.done       = done_q;
  assign bus.wr_drop    = drop_q;
endmodule

// File: doc/edge_mask_tx.md
Name: edge_mask_tx

Overview:
- Transmit side of the 128-bit edge-mask stream.
- Host loads a 4096-bit edge map as 128 × 32-bit words, then pulses start.
- The block streams the map as 32 beats of 128 bits, phase-locked to the accumulator's 5-bit beat counter (rx_sel).
- The accumulator ORs each complete frame into its result map; word n lands at accumulator readout bank n/16, word n%16.

Parameters:
- WORD_W, 32, host write word width.
- BEAT_W, 128, stream beat width.
- BEATS, 32, beats per frame (power of two; rx_sel width = log2(BEATS)).
- MAP_W, WORD_W*128 (4096), edge map size; must equal BEAT_W*BEATS.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous reset, active-high.
- wr_en  in  1  host word write strobe.
- wr_addr  in  7  word index 0..127.
- wr_data  in  32  word data.
- wr_drop  out  1  one-cycle pulse: write rejected because busy.
- start  in  1  request one frame transmission.
- rx_sel  in  5  accumulator beat counter (0..31, increments every cycle, wraps).
- edge_mask  out  128  registered stream beat.
- mask_valid  out  1  high while edge_mask carries a frame beat.
- beat_idx  out  5  index of the beat currently on edge_mask.
- busy  out  1  high in ARMED and SEND.
- done  out  1  one-cycle pulse after the last beat.

Behaviour:
- Reset (asynchronous, RST=1):
  - map cleared to 0; FSM to IDLE.
  - edge_mask=0, mask_valid=0, beat_idx=0, busy=0, done=0, wr_drop=0.
  - Reset asserted mid-frame aborts immediately; edge_mask goes to 0 asynchronously.
- Map layout: word a occupies map[32a+31:32a].
- Beat k transmits map[MAP_W-1-128k -: 128], most significant slice first. The receiver left-shifts 128 bits per beat, so beat 0 ends at the top of its map.
- Writes:
  - Accepted only when busy=0: map word wr_addr <= wr_data, one-cycle write latency.
  - When wr_en=1 and busy=1, the map is unchanged and wr_drop pulses the next cycle.
  - A write and start in the same IDLE cycle: the write is applied first, and the frame includes it.
- FSM:
  - IDLE: edge_mask=0, mask_valid=0. start=1 -> ARMED.
  - ARMED: wait for rx_sel==31. On that cycle, register beat 0, set mask_valid=1, beat_idx=0 -> SEND. Beat 0 is therefore presented while rx_sel==0.
  - SEND: each cycle advance beat_idx and register the next beat.
    - After beat 31 (presented while rx_sel==31): next cycle edge_mask=0, mask_valid=0, done=1 -> IDLE.
    - done coincides with rx_sel==0, the cycle in which the receiver commits the frame.
- Idle output is forced to 0 because the receiver ORs the stream every frame unconditionally.
- start while busy is ignored (not queued).
- start in ARMED has no effect. If rx_sel==31 on the same cycle as the IDLE->ARMED transition, sending begins the following frame (one full frame wait), so alignment is never partial.
- rx_sel jump (receiver reset mid-SEND): not tracked. The frame completes by own count; only the receiver's result is corrupted.
- Worst-case start-to-beat-0 latency: 33 cycles. Best case: 2 cycles.
- Map content is preserved after a frame; it is not cleared on done.

Optional Feature:
- Macro EDGE_TX_REPEAT_EN.
- Defined:
  - If start is high in the cycle beat 31 is registered, beat 0 of a new frame follows in the next cycle (rx_sel==0).
  - done still pulses for one cycle at each frame boundary; mask_valid stays 1; busy stays 1.
  - Gap-free continuous streaming results.
- Undefined: always returns to IDLE after beat 31, as above; a held start re-arms and waits a full frame.

Decomposition:
- Shared package edge_stream_pkg, holding:
  - constants WORD_W, BEAT_W, BEATS, MAP_WORDS=128, SEL_W=5;
  - the FSM state encoding (IDLE=2'd0, ARMED=2'd1, SEND=2'd2);
  - a beat-slice function (map, k) -> 128 bits, reused by the receiver model in the bench.
- One sub-module is natural: edge_map_store (128×32 word-write register file with a 128-bit beat read port, addressed by beat index).
- The FSM and output registers stay in the top module.

Test Plan:
- Reset, then idle 64 cycles with free-running rx_sel -> edge_mask==0 and mask_valid==0 throughout; done never pulses.
- Write word 127=32'hDEADBEEF, word 0=32'h00000001, then start at rx_sel==5:
  - beat 0 appears at rx_sel==0 with bits [127:96]=DEADBEEF;
  - beat 31 at rx_sel==31 with bit 0 set;
  - done at the following rx_sel==0;
  - receiver-model readout bank 7 word 15 = DEADBEEF, bank 0 word 0 = 1.
- Write word 3=32'h5A5A5A5A while in SEND -> wr_drop pulses; the frame carries the old value; after done, a rewrite succeeds and the next frame carries 5A5A5A5A.
- start asserted on the same cycle as rx_sel==31 from IDLE -> beat 0 delayed one full frame (33 cycles); start pulsed again mid-SEND -> ignored, exactly one done.
- Assert RST at beat 17 -> edge_mask=0 and busy=0 asynchronously; map cleared; a fresh start after release sends an all-zero frame.
- With EDGE_TX_REPEAT_EN defined and start held, run 3 frames -> 96 consecutive valid beats with no gap and 3 done pulses each at rx_sel==0; without the macro -> a gap of ≥32 cycles between frames.
